phy_link_ctrl: RTL
==================

PHY_LINK_CTRL -- requirements
Module: phy_link_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD, default 1000, giving the PHY-management reset pulse length in CLK cycles (min 1).
REQ-002 SHALL have parameter TIMEOUT, default 5000000, giving the maximum cycles spent in any wait state (100 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE, default 50000, giving the consecutive cycles tx_ready and rx_ready must both be high before link-up.
REQ-004 SHALL have port CLK, input, 1 bit: 50 MHz management clock; the only clock.
REQ-005 SHALL have port RSTn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port osc_done, input, 1 bit: Si5338 init complete, synchronous to CLK.
REQ-007 SHALL have port pll_locked, input, 1 bit: PHY PLL lock, asynchronous.
REQ-008 SHALL have port reconfig_busy, input, 1 bit: reconfig controller calibrating, asynchronous.
REQ-009 SHALL have port tx_ready, input, 1 bit: PHY TX ready, asynchronous.
REQ-010 SHALL have port rx_ready, input, 1 bit: PHY RX ready / block lock, asynchronous.
REQ-011 SHALL have port phy_mgmt_rst, output, 1 bit: active-high reset to the PHY and reconfig management ports.
REQ-012 SHALL have port xgmii_rst_req, output, 1 bit: active-high request into the 156 MHz datapath reset synchronizer.
REQ-013 SHALL have port link_up, output, 1 bit: link established.
REQ-014 SHALL have port state, output, 3 bits: current FSM encoding.
REQ-015 SHALL have port retry_cnt, output, 8 bits: number of link recoveries.

Function
REQ-016 SHALL pass pll_locked, reconfig_busy, tx_ready and rx_ready through 2-flop synchronizers; all decisions SHALL use the synchronized values (2-cycle input latency).
REQ-017 SHALL implement the FSM states IDLE=0, RST=1, WAIT_PLL=2, WAIT_CAL=3, WAIT_RDY=4, UP=5; codes 6-7 SHALL go to IDLE.
REQ-018 IDLE SHALL go to RST when osc_done=1.
REQ-019 RST SHALL hold for exactly RST_HOLD cycles, then go to WAIT_PLL.
REQ-020 WAIT_PLL SHALL go to WAIT_CAL when pll_locked=1.
REQ-021 WAIT_CAL SHALL go to WAIT_RDY when reconfig_busy=0.
REQ-022 WAIT_RDY SHALL count cycles with tx_ready&rx_ready=1, clear the count on any low cycle, and go to UP when the count reaches STABLE.
REQ-023 UP SHALL go to RST if pll_locked=0, rx_ready=0, tx_ready=0 or reconfig_busy=1 on any cycle.
REQ-024 The WAIT_PLL, WAIT_CAL and WAIT_RDY states SHALL go to RST when the per-state timer reaches TIMEOUT; the timer SHALL clear on every state entry.
REQ-025 Every entry to RST from UP, or on a timeout, SHALL increment retry_cnt, which saturates at 255; entry from IDLE SHALL NOT increment it.
REQ-026 osc_done=0 SHALL force IDLE from any state; priority is osc_done loss > timeout/fault > normal advance.
REQ-027 The outputs SHALL be registered and decoded from the next state: phy_mgmt_rst=1 in IDLE and RST; xgmii_rst_req=0 only in UP; link_up=1 only in UP.
REQ-028 The timer width SHALL be sized for max(RST_HOLD, TIMEOUT, STABLE) and the timer SHALL NOT wrap.

Reset
REQ-029 RSTn=0 on a rising CLK edge SHALL set state=IDLE, phy_mgmt_rst=1, xgmii_rst_req=1, link_up=0, retry_cnt=0, timers=0 and synchronizers=0.
REQ-030 Reset asserted mid-operation (including while in UP) SHALL take effect at the next edge, with no retry increment.

Configuration
REQ-031 With macro PHY_LINK_CTRL_RETRY_EN defined, the block SHALL auto-recover as described in REQ-023 to REQ-025.
REQ-032 Without PHY_LINK_CTRL_RETRY_EN, a fault or timeout SHALL go to IDLE-like hold state RST and remain there, with phy_mgmt_rst=1, until RSTn or osc_done toggles; retry_cnt SHALL be tied to 0.

Verification (RST_HOLD=8, TIMEOUT=100, STABLE=16, macro defined)
REQ-033 Nominal: osc_done=1, then pll_locked=1, reconfig_busy=0, ready=1 held -> phy_mgmt_rst high for 8 cycles, link_up rises after 16 stable cycles plus sync latency, retry_cnt=0.
REQ-034 Ready glitch: rx_ready drops 1 cycle at count 10 in WAIT_RDY -> count restarts; link_up delayed by 10+ cycles; no retry.
REQ-035 Timeout: pll_locked held 0 -> RST re-entered after 100 cycles in WAIT_PLL, retry_cnt increments every 108+ cycles, saturating at 255.
REQ-036 Link loss: in UP, pll_locked=0 -> within 3 cycles link_up=0, xgmii_rst_req=1, phy_mgmt_rst=1, retry_cnt=1.
REQ-037 Priority: osc_done=0 coincident with a timeout -> state=IDLE, retry_cnt unchanged.
REQ-038 Reset in UP: RSTn=0 for 1 cycle -> all outputs at their reset values next edge, retry_cnt=0.

Source files
------------

// File: rtl/phy_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phy_link_ctrl
// Purpose  : Bring-up and recovery sequencer for a 10G PHY. It waits for the
//            oscillator, pulses the PHY management reset, then waits for PLL
//            lock, reconfig calibration and a stable TX/RX ready window before
//            declaring the link up. Every wait state has a timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RST_HOLD      : PHY-management reset pulse length in CLK cycles (>= 1)
//   TIMEOUT       : maximum cycles spent in any wait state
//   STABLE        : consecutive tx_ready&rx_ready cycles required for link-up
// Ports
//   CLK           : in  - 50 MHz management clock, the only clock
//   RSTn          : in  - synchronous active-low reset
//   osc_done      : in  - oscillator init complete (already CLK-synchronous)
//   pll_locked    : in  - PHY PLL lock (asynchronous)
//   reconfig_busy : in  - reconfig controller calibrating (asynchronous)
//   tx_ready      : in  - PHY TX ready (asynchronous)
//   rx_ready      : in  - PHY RX ready / block lock (asynchronous)
//   phy_mgmt_rst  : out - active-high reset to PHY and reconfig mgmt ports
//   xgmii_rst_req : out - active-high request to the 156 MHz reset synchronizer
//   link_up       : out - link established
//   state         : out - current FSM encoding
//   retry_cnt     : out - number of link recoveries (saturates at 255)
// Configuration macro
//   PHY_LINK_CTRL_RETRY_EN : defined   -> faults/timeouts re-run the reset
//                                          sequence and count recoveries
//                            undefined -> faults/timeouts park in RST until
//                                          RSTn or osc_done toggles
// ============================================================================
module phy_link_ctrl #(
  parameter int RST_HOLD = 1000,
  parameter int TIMEOUT  = 5000000,
  parameter int STABLE   = 50000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       osc_done,
  input  logic       pll_locked,
  input  logic       reconfig_busy,
  input  logic       tx_ready,
  input  logic       rx_ready,
  output logic       phy_mgmt_rst,
  output logic       xgmii_rst_req,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] retry_cnt
);

  localparam int MAX_AB = (RST_HOLD > TIMEOUT) ? RST_HOLD : TIMEOUT;
  localparam int MAXC   = (MAX_AB > STABLE) ? MAX_AB : STABLE;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAXC);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_WAIT_PLL = 3'd2,
    S_WAIT_CAL = 3'd3,
    S_WAIT_RDY = 3'd4,
    S_UP       = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] stable_q, stable_d;
  logic          hold_q, hold_d;
  logic [3:0]    sync1_q, sync2_q;
  logic          phy_rst_q, xgmii_rst_q, link_up_q;
  logic          fault;
  logic          pll_s, busy_s, tx_s, rx_s;
  logic          both_rdy;

  assign pll_s    = sync2_q[3];
  assign busy_s   = sync2_q[2];
  assign tx_s     = sync2_q[1];
  assign rx_s     = sync2_q[0];
  assign both_rdy = tx_s & rx_s;

`ifdef PHY_LINK_CTRL_RETRY_EN
  logic       bump;
  logic [7:0] retry_q;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. osc_done loss overrides everything, then faults and
  // timeouts, then the normal forward progression.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fault   = 1'b0;
`ifdef PHY_LINK_CTRL_RETRY_EN
    bump    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (osc_done) state_d = S_RST;
      end
      S_RST: begin
        // A parked (non-recovering) controller never leaves RST on its own.
        if (!hold_q && (timer_q == HOLD_LAST)) state_d = S_WAIT_PLL;
      end
      S_WAIT_PLL: begin
        if (timer_q == TMO_LAST) fault = 1'b1;
        else if (pll_s)          state_d = S_WAIT_CAL;
      end
      S_WAIT_CAL: begin
        if (timer_q == TMO_LAST) fault = 1'b1;
        else if (!busy_s)        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (timer_q == TMO_LAST)                  fault = 1'b1;
        else if (both_rdy && stable_q == STB_LAST) state_d = S_UP;
      end
      S_UP: begin
        if (!pll_s || !rx_s || !tx_s || busy_s) fault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (fault) begin
      state_d = S_RST;
`ifdef PHY_LINK_CTRL_RETRY_EN
      bump    = 1'b1;
`else
      hold_d  = 1'b1;
`endif
    end

    if (!osc_done) begin
      state_d = S_IDLE;
      hold_d  = 1'b0;
`ifdef PHY_LINK_CTRL_RETRY_EN
      bump    = 1'b0;
`endif
    end
  end

  // Per-state timer: zero on every state change, saturates instead of wrapping.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)   timer_d = '0;
    else if (timer_q != CNT_MAX) timer_d = timer_q + 1'b1;
  end

  // Stable-ready counter only runs while remaining in WAIT_RDY with both
  // ready inputs high; any low cycle or state change restarts it.
  always_comb begin
    stable_d = '0;
    if ((state_q == S_WAIT_RDY) && (state_d == S_WAIT_RDY) && both_rdy &&
        (stable_q != CNT_MAX))
      stable_d = stable_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      stable_q    <= '0;
      hold_q      <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      phy_rst_q   <= 1'b1;
      xgmii_rst_q <= 1'b1;
      link_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      hold_q      <= hold_d;
      sync1_q     <= {pll_locked, reconfig_busy, tx_ready, rx_ready};
      sync2_q     <= sync1_q;
      // Outputs decoded from the next state so they line up with state_q.
      phy_rst_q   <= (state_d == S_IDLE) || (state_d == S_RST);
      xgmii_rst_q <= (state_d != S_UP);
      link_up_q   <= (state_d == S_UP);
    end
  end

`ifdef PHY_LINK_CTRL_RETRY_EN
  always_ff @(posedge CLK) begin
    if (!RSTn)                         retry_q <= 8'd0;
    else if (bump && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
  end
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = 8'd0;
`endif

  assign phy_mgmt_rst  = phy_rst_q;
  assign xgmii_rst_req = xgmii_rst_q;
  assign link_up       = link_up_q;
  assign state         = state_q;

endmodule
`default_nettype wire
